// File: rtl/bus_xfer_sequencer_pkg.sv
// Shared bus node codes, field selects and request type for the bus transfer sequencer.
// Used by bus_xfer_fifo and bus_xfer_sequencer.
package bus_pkg;

    localparam int NUM_BUS_NODES = 24;

    localparam logic [4:0] SEL_IDLE = 5'd31;

    // Source codes (bus mux select)
    localparam logic [4:0] SRC_R0     = 5'd0;
    localparam logic [4:0] SRC_R15    = 5'd15;
    localparam logic [4:0] SRC_HI     = 5'd16;
    localparam logic [4:0] SRC_LO     = 5'd17;
    localparam logic [4:0] SRC_ZHIGH  = 5'd18;
    localparam logic [4:0] SRC_ZLOW   = 5'd19;
    localparam logic [4:0] SRC_PC     = 5'd20;
    localparam logic [4:0] SRC_MDR    = 5'd21;
    localparam logic [4:0] SRC_INPORT = 5'd22;
    localparam logic [4:0] SRC_CSIGN  = 5'd23;

    // Destination codes (load enable index)
    localparam logic [4:0] DST_R0      = 5'd0;
    localparam logic [4:0] DST_R15     = 5'd15;
    localparam logic [4:0] DST_HI      = 5'd16;
    localparam logic [4:0] DST_LO      = 5'd17;
    localparam logic [4:0] DST_Y       = 5'd18;
    localparam logic [4:0] DST_MAR     = 5'd19;
    localparam logic [4:0] DST_PC      = 5'd20;
    localparam logic [4:0] DST_MDR     = 5'd21;
    localparam logic [4:0] DST_OUTPORT = 5'd22;
    localparam logic [4:0] DST_IR      = 5'd23;

    // Field select encodings
    localparam logic [1:0] FSEL_LIT = 2'b00;
    localparam logic [1:0] FSEL_RA  = 2'b01;
    localparam logic [1:0] FSEL_RB  = 2'b10;
    localparam logic [1:0] FSEL_RC  = 2'b11;

    // IR register field LSB positions (each field is 4 bits)
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    typedef struct packed {
        logic [4:0] src;
        logic [4:0] dst;
    } xfer_req_t;

    // Map a field select onto a literal code or a register from IR
    function automatic logic [4:0] resolve_code(
        input logic [1:0]  sel,
        input logic [4:0]  lit,
        input logic [31:0] ir
    );
        logic [4:0] r;
        r = lit;
        unique case (sel)
            FSEL_LIT: r = lit;
            FSEL_RA:  r = {1'b0, ir[IR_RA_LSB +: 4]};
            FSEL_RB:  r = {1'b0, ir[IR_RB_LSB +: 4]};
            FSEL_RC:  r = {1'b0, ir[IR_RC_LSB +: 4]};
            default:  r = lit;
        endcase
        return r;
    endfunction

    // Invalid destinations produce no load enable
    function automatic logic [NUM_BUS_NODES-1:0] dst_onehot(
        input logic [4:0] dst
    );
        logic [NUM_BUS_NODES-1:0] r;
        r = '0;
        if (dst < 5'(NUM_BUS_NODES)) begin
            r = NUM_BUS_NODES'(1) << dst;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_xfer_sequencer_fifo.sv
// Synchronous request FIFO for the bus transfer sequencer.
// DEPTH entries of xfer_req_t; flags come straight from registered pointers.
module bus_xfer_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      clear_n,
    input  logic      push_i,
    input  xfer_req_t wdata_i,
    input  logic      pop_i,
    output xfer_req_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    xfer_req_t     mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer update; reset flushes all entries
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Storage write, no reset needed
    always_ff @(posedge clock) begin
        if (push_i && !full_o) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Bus transfer sequencer: queues transfer requests, issues one per clock.
// Optional build macro BUS_XFER_BYPASS_EN lets requests skip an empty FIFO.
module bus_xfer_sequencer
    import bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_src,
    input  logic [1:0]               req_src_sel,
    input  logic [4:0]               req_dst,
    input  logic [1:0]               req_dst_sel,
    input  logic [31:0]              IR,
    input  logic                     stall,
    output logic [4:0]               Sout,
    output logic [NUM_BUS_NODES-1:0] bus_in_en,
    output logic                     busy,
    output logic [CNT_W-1:0]         xfer_count,
    output logic                     err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t                   state_q;
    logic [4:0]               sout_q;
    logic [NUM_BUS_NODES-1:0] en_q;
    logic [CNT_W-1:0]         count_q;
    logic                     err_q;

    xfer_req_t in_req;
    xfer_req_t head_req;
    xfer_req_t issue_req;
    logic      full;
    logic      empty;
    logic      accept;
    logic      bypass;
    logic      fifo_push;
    logic      pop;
    logic      issue;
    logic      unused_ir;

    assign unused_ir = ^{IR[31:27], IR[14:0]};

    assign in_req.src = resolve_code(req_src_sel, req_src, IR);
    assign in_req.dst = resolve_code(req_dst_sel, req_dst, IR);

    assign req_ready = !full;
    assign accept    = req_valid && !full;

`ifdef BUS_XFER_BYPASS_EN
    assign bypass    = accept && empty && !stall;
`else
    assign bypass    = 1'b0;
`endif

    assign fifo_push = accept && !bypass;
    assign pop       = !empty && !stall;
    assign issue     = pop || bypass;
    assign issue_req = pop ? head_req : in_req;

    bus_xfer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .clear_n (clear_n),
        .push_i  (fifo_push),
        .wdata_i (in_req),
        .pop_i   (pop),
        .rdata_o (head_req),
        .full_o  (full),
        .empty_o (empty)
    );

    // Issue FSM with registered bus select, enables, count and error
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            sout_q  <= SEL_IDLE;
            en_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (issue) begin
            state_q <= ST_ISSUE;
            sout_q  <= issue_req.src;
            en_q    <= dst_onehot(issue_req.dst);
            count_q <= count_q + 1'b1;
            if ((issue_req.src >= 5'(NUM_BUS_NODES)) ||
                (issue_req.dst >= 5'(NUM_BUS_NODES))) begin
                err_q <= 1'b1;
            end
        end else if (!empty) begin
            state_q <= ST_STALL;
            sout_q  <= SEL_IDLE;
            en_q    <= '0;
        end else begin
            state_q <= ST_IDLE;
            sout_q  <= SEL_IDLE;
            en_q    <= '0;
        end
    end

    assign Sout       = sout_q;
    assign bus_in_en  = en_q;
    assign xfer_count = count_q;
    assign err        = err_q;
    assign busy       = !empty || (state_q == ST_ISSUE);

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed testbench for bus_xfer_sequencer.
// Build with +define+BUS_XFER_BYPASS_EN to exercise the bypass variant.
module tb_bus_xfer_sequencer;

    logic        clock;
    logic        clear_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_src;
    logic [1:0]  req_src_sel;
    logic [4:0]  req_dst;
    logic [1:0]  req_dst_sel;
    logic [31:0] IR;
    logic        stall;
    logic [4:0]  Sout;
    logic [23:0] bus_in_en;
    logic        busy;
    logic [15:0] xfer_count;
    logic        err;

    int checks = 0;
    int errors = 0;

    bus_xfer_sequencer #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_src     (req_src),
        .req_src_sel (req_src_sel),
        .req_dst     (req_dst),
        .req_dst_sel (req_dst_sel),
        .IR          (IR),
        .stall       (stall),
        .Sout        (Sout),
        .bus_in_en   (bus_in_en),
        .busy        (busy),
        .xfer_count  (xfer_count),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [4:0] s, input logic [1:0] ss,
                           input logic [4:0] d, input logic [1:0] ds);
        req_valid   = 1'b1;
        req_src     = s;
        req_src_sel = ss;
        req_dst     = d;
        req_dst_sel = ds;
    endtask

    task automatic push(input logic [4:0] s, input logic [1:0] ss,
                        input logic [4:0] d, input logic [1:0] ds);
        set_req(s, ss, d, ds);
        tick();
        req_valid = 1'b0;
    endtask

    // Advance to the cycle where a request accepted last edge is on the bus
    task automatic to_issue();
`ifndef BUS_XFER_BYPASS_EN
        tick();
`endif
    endtask

    initial begin
        clear_n     = 1'b0;
        req_valid   = 1'b0;
        req_src     = '0;
        req_src_sel = '0;
        req_dst     = '0;
        req_dst_sel = '0;
        IR          = '0;
        stall       = 1'b0;
        @(negedge clock);
        tick();
        tick();
        clear_n = 1'b1;

        // Reset state
        chk("rst_sout", 32'(Sout), 32'd31);
        chk("rst_en", 32'(bus_in_en), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_count", 32'(xfer_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Literal PC -> MAR
        push(5'd20, 2'b00, 5'd19, 2'b00);
        chk("lit_busy", 32'(busy), 32'd1);
`ifndef BUS_XFER_BYPASS_EN
        chk("lit_wait_sout", 32'(Sout), 32'd31);
        chk("lit_wait_en", 32'(bus_in_en), 32'h0);
`endif
        to_issue();
        chk("lit_sout", 32'(Sout), 32'd20);
        chk("lit_en", 32'(bus_in_en), 32'h080000);
        chk("lit_count", 32'(xfer_count), 32'd1);
        tick();
        chk("lit_idle_sout", 32'(Sout), 32'd31);
        chk("lit_idle_en", 32'(bus_in_en), 32'h0);
        chk("lit_idle_busy", 32'(busy), 32'd0);

        // IR field resolution: src=Rb (2), dst=Ra (6)
        IR = 32'h0B100000;
        push(5'd0, 2'b10, 5'd0, 2'b01);
        IR = 32'hFFFFFFFF;
        to_issue();
        chk("ir_sout", 32'(Sout), 32'd2);
        chk("ir_en", 32'(bus_in_en), 32'h000040);
        chk("ir_count", 32'(xfer_count), 32'd2);
        IR = '0;
        tick();

        // Fill under stall, then drain back-to-back
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(5'(i), 2'b00, 5'(i + 4), 2'b00);
        end
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("stall_sout", 32'(Sout), 32'd31);
        chk("stall_en", 32'(bus_in_en), 32'h0);
        chk("stall_busy", 32'(busy), 32'd1);
        push(5'd9, 2'b00, 5'd9, 2'b00);
        chk("full_ready2", 32'(req_ready), 32'd0);
        stall = 1'b0;
        tick();
        chk("b2b_sout1", 32'(Sout), 32'd1);
        chk("b2b_en1", 32'(bus_in_en), 32'h000020);
        tick();
        chk("b2b_sout2", 32'(Sout), 32'd2);
        chk("b2b_en2", 32'(bus_in_en), 32'h000040);
        tick();
        chk("b2b_sout3", 32'(Sout), 32'd3);
        chk("b2b_en3", 32'(bus_in_en), 32'h000080);
        tick();
        chk("b2b_sout4", 32'(Sout), 32'd4);
        chk("b2b_en4", 32'(bus_in_en), 32'h000100);
        tick();
        chk("b2b_idle_sout", 32'(Sout), 32'd31);
        chk("b2b_idle_en", 32'(bus_in_en), 32'h0);
        chk("b2b_count", 32'(xfer_count), 32'd6);
        chk("b2b_ready", 32'(req_ready), 32'd1);
        chk("b2b_err", 32'(err), 32'd0);

        // Invalid destination
        push(5'd0, 2'b00, 5'd27, 2'b00);
        to_issue();
        chk("bad_dst_sout", 32'(Sout), 32'd0);
        chk("bad_dst_en", 32'(bus_in_en), 32'h0);
        chk("bad_dst_err", 32'(err), 32'd1);
        chk("bad_dst_count", 32'(xfer_count), 32'd7);
        tick();
        tick();
        chk("err_sticky", 32'(err), 32'd1);

        // Invalid source, legal destination R1
        push(5'd30, 2'b00, 5'd1, 2'b00);
        to_issue();
        chk("bad_src_sout", 32'(Sout), 32'd30);
        chk("bad_src_en", 32'(bus_in_en), 32'h000002);
        chk("bad_src_count", 32'(xfer_count), 32'd8);
        tick();

        // Reset with three queued entries
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(5'(10 + i), 2'b00, 5'(10 + i), 2'b00);
        end
        chk("mid_busy", 32'(busy), 32'd1);
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        stall = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_count", 32'(xfer_count), 32'd0);
        tick();
        tick();
        chk("mid_rst_sout", 32'(Sout), 32'd31);
        chk("mid_rst_en", 32'(bus_in_en), 32'h0);
        chk("mid_rst_count2", 32'(xfer_count), 32'd0);

        // Counter wrap: 65537 streamed transfers
        set_req(5'd1, 2'b00, 5'd1, 2'b00);
        for (int i = 0; i < 65537; i++) begin
            tick();
        end
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("wrap_count", 32'(xfer_count), 32'd1);
        chk("wrap_err", 32'(err), 32'd0);
        chk("wrap_sout", 32'(Sout), 32'd31);

        // Ordering: queued request goes ahead of a newer one
        stall = 1'b1;
        push(5'd16, 2'b00, 5'd18, 2'b00);
        stall = 1'b0;
        set_req(5'd17, 2'b00, 5'd16, 2'b00);
        tick();
        req_valid = 1'b0;
        chk("ord_sout1", 32'(Sout), 32'd16);
        chk("ord_en1", 32'(bus_in_en), 32'h040000);
        tick();
        chk("ord_sout2", 32'(Sout), 32'd17);
        chk("ord_en2", 32'(bus_in_en), 32'h010000);
        tick();
        chk("ord_idle", 32'(Sout), 32'd31);
        chk("ord_count", 32'(xfer_count), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
